// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
//   Turn sequencer for a two-player 3x3 board game. It collects one move per
//   turn from a human (button edges, with an inactivity timeout that plays the
//   lowest free cell) or from an AI engine (valid/cell handshake). It strobes
//   the chosen cell into the board datapath, then reads back the win/full
//   status and either hands the turn over or ends the game.
//
// Ports
//   clk         in   1  rising-edge clock
//   reset       in   1  asynchronous, active-low reset
//   btn         in   9  human cell buttons (level), bit0 = cell a .. bit8 = cell i
//   comp_mode   in   1  1 = player 2 is played by the AI engine
//   comp_valid  in   1  AI move valid
//   comp_cell   in   4  AI move cell index (0..8; larger values are illegal)
//   occupied    in   9  per-cell occupancy from the board
//   p1_win      in   1  player 1 has a line
//   p2_win      in   1  player 2 has a line
//   grid_full   in   1  no free cells remain
//   new_game    in   1  synchronous restart, overrides every other transition
//   place       out  9  one-hot cell write strobe, one cycle per move
//   place_p2    out  1  strobe belongs to player 2
//   turn_p2     out  1  player 2 is the side to move
//   ai_start    out  1  one-cycle pulse on entry to WAIT_AI
//   illegal     out  1  one-cycle pulse for a rejected move
//   timeout     out  1  one-cycle pulse when the human turn expires
//   game_over   out  1  high only in OVER
//   move_count  out  4  moves committed this game, saturating at 9
//   state       out  3  current FSM state code
// -----------------------------------------------------------------------------
module game_sequencer #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int TCW            = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [8:0] btn,
   input  logic       comp_mode,
   input  logic       comp_valid,
   input  logic [3:0] comp_cell,
   input  logic [8:0] occupied,
   input  logic       p1_win,
   input  logic       p2_win,
   input  logic       grid_full,
   input  logic       new_game,
   output logic [8:0] place,
   output logic       place_p2,
   output logic       turn_p2,
   output logic       ai_start,
   output logic       illegal,
   output logic       timeout,
   output logic       game_over,
   output logic [3:0] move_count,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WAIT_HUMAN = 3'd1,
      WAIT_AI    = 3'd2,
      COMMIT     = 3'd3,
      CHECK      = 3'd4,
      OVER       = 3'd5
   } state_t;

   localparam logic [3:0] NO_CELL = 4'hF;

   // Index of the lowest set bit, NO_CELL when the vector is empty.
   function automatic logic [3:0] lowest_set(input logic [8:0] v);
      lowest_set = NO_CELL;
      for (int i = 8; i >= 0; i--) begin
         if (v[i]) lowest_set = 4'(i);
      end
   endfunction

   // One-hot decode; an out-of-range index (board already full) decodes to 0.
   function automatic logic [8:0] one_hot(input logic [3:0] c);
      for (int i = 0; i < 9; i++) begin
         one_hot[i] = (c == 4'(i));
      end
   endfunction

   state_t           state_q, state_d;
   logic [8:0]       btn_q;
   logic [3:0]       cell_q, cell_d;
   logic [TCW-1:0]   tmo_cnt, tmo_d;
   logic [3:0]       count_d;
   logic             turn_d;
   logic             ai_start_d;

   logic [8:0]       press;
   logic [3:0]       press_idx;
   logic [3:0]       free_idx;
   logic [15:0]      free16;
   logic             tmo_hit;

   assign press     = btn & ~btn_q;
   assign press_idx = lowest_set(press);
   assign free_idx  = lowest_set(~occupied);
   // Zero-extended free map so an out-of-range AI index simply reads "not free".
   assign free16    = {7'd0, ~occupied};
   assign tmo_hit   = (tmo_cnt == TCW'(TIMEOUT_CYCLES - 1));
   assign state     = state_q;

   always_ff @(posedge clk or negedge reset) begin
      // NOTE: registered state uses non-blocking (<=) so every flop samples pre-edge values.
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path infers a latch.
      state_d   = state_q;
      cell_d    = cell_q;
      tmo_d     = '0;
      count_d   = move_count;
      turn_d    = turn_p2;
      place     = '0;
      place_p2  = 1'b0;
      illegal   = 1'b0;
      timeout   = 1'b0;
      game_over = 1'b0;

      case (state_q)
         IDLE: begin
            turn_d  = 1'b0;
            count_d = '0;
            state_d = WAIT_HUMAN;
         end
         WAIT_HUMAN: begin
            if (press != '0 && free16[press_idx]) begin
               cell_d  = press_idx;
               state_d = COMMIT;
            end else begin
               illegal = (press != '0);
               if (tmo_hit) begin
                  timeout = 1'b1;
                  cell_d  = free_idx;
                  state_d = COMMIT;
               end else begin
                  tmo_d = tmo_cnt + TCW'(1);
               end
            end
         end
         WAIT_AI: begin
            if (comp_valid) begin
               state_d = COMMIT;
               if (free16[comp_cell]) begin
                  cell_d = comp_cell;
               end else begin
                  illegal = 1'b1;
                  cell_d  = free_idx;
               end
            end
         end
         COMMIT: begin
            place    = one_hot(cell_q);
            place_p2 = turn_p2;
            if (move_count != 4'd9) count_d = move_count + 4'd1;
            state_d  = CHECK;
         end
         CHECK: begin
            if (p1_win || p2_win || grid_full || move_count == 4'd9) begin
               state_d = OVER;
            end else begin
               turn_d  = ~turn_p2;
               state_d = (comp_mode && !turn_p2) ? WAIT_AI : WAIT_HUMAN;
            end
         end
         OVER: begin
            game_over = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // Restart wins over everything; a move decided this cycle is dropped
      // without its event pulse, and the game counters restart immediately.
      if (new_game) begin
         state_d = IDLE;
         illegal = 1'b0;
         timeout = 1'b0;
         tmo_d   = '0;
         count_d = '0;
         turn_d  = 1'b0;
      end

      ai_start_d = (state_d == WAIT_AI) && (state_q != WAIT_AI);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_q      <= '0;
         cell_q     <= '0;
         tmo_cnt    <= '0;
         move_count <= '0;
         turn_p2    <= 1'b0;
         ai_start   <= 1'b0;
      end else begin
         btn_q      <= btn;
         cell_q     <= cell_d;
         tmo_cnt    <= tmo_d;
         move_count <= count_d;
         turn_p2    <= turn_d;
         ai_start   <= ai_start_d;
      end
   end

endmodule

// File: tb/tb_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_sequencer
//   Directed bench for game_sequencer. A table of one-cycle vectors walks a
//   full game (human/human, then human/AI, illegal moves, simultaneous presses,
//   win, restart); hand-written sequences cover the turn timeout and a reset
//   that lands in the middle of a COMMIT cycle.
// -----------------------------------------------------------------------------
module tb_game_sequencer;

   localparam int T = 20;

   logic       clk = 1'b0;
   logic       reset;
   logic [8:0] btn;
   logic       comp_mode;
   logic       comp_valid;
   logic [3:0] comp_cell;
   logic [8:0] occupied;
   logic       p1_win, p2_win, grid_full;
   logic       new_game;
   logic [8:0] place;
   logic       place_p2, turn_p2, ai_start, illegal, timeout, game_over;
   logic [3:0] move_count;
   logic [2:0] state;

   int checks   = 0;
   int failures = 0;

   game_sequencer #(.TIMEOUT_CYCLES(T), .TCW(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .btn        (btn),
      .comp_mode  (comp_mode),
      .comp_valid (comp_valid),
      .comp_cell  (comp_cell),
      .occupied   (occupied),
      .p1_win     (p1_win),
      .p2_win     (p2_win),
      .grid_full  (grid_full),
      .new_game   (new_game),
      .place      (place),
      .place_p2   (place_p2),
      .turn_p2    (turn_p2),
      .ai_start   (ai_start),
      .illegal    (illegal),
      .timeout    (timeout),
      .game_over  (game_over),
      .move_count (move_count),
      .state      (state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       ng;
      logic [8:0] btn;
      logic [8:0] occ;
      logic       cm;
      logic       cv;
      logic [3:0] cc;
      logic       w1;
      logic [21:0] exp;
   } vec_t;

   vec_t vq[$];

   // Packed view: {state, place, place_p2, turn_p2, illegal, timeout, ai_start, game_over, move_count}
   function automatic logic [21:0] outs();
      return {state, place, place_p2, turn_p2, illegal, timeout, ai_start, game_over, move_count};
   endfunction

   task automatic add(input logic ng, input logic [8:0] b, input logic [8:0] occ,
                      input logic cm, input logic cv, input logic [3:0] cc, input logic w1,
                      input logic [2:0] st, input logic [8:0] pl, input logic pp2,
                      input logic tr, input logic il, input logic to, input logic ai,
                      input logic go, input logic [3:0] mc);
      vec_t v;
      v.ng = ng; v.btn = b; v.occ = occ; v.cm = cm; v.cv = cv; v.cc = cc; v.w1 = w1;
      v.exp = {st, pl, pp2, tr, il, to, ai, go, mc};
      vq.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int seen;

      reset = 1'b0; btn = '0; comp_mode = 1'b0; comp_valid = 1'b0; comp_cell = '0;
      occupied = '0; p1_win = 1'b0; p2_win = 1'b0; grid_full = 1'b0; new_game = 1'b0;

      //   ng  btn     occ    cm cv cc w1   st place  pp2 tr il to ai go mc
      add(0, 9'h000, 9'h000, 0, 0, 0, 0,  0, 9'h000, 0, 0, 0, 0, 0, 0, 0); // IDLE after reset
      add(0, 9'h010, 9'h000, 0, 0, 0, 0,  1, 9'h000, 0, 0, 0, 0, 0, 0, 0); // btn4 rises
      add(0, 9'h010, 9'h000, 0, 0, 0, 0,  3, 9'h010, 0, 0, 0, 0, 0, 0, 0); // commit cell e
      add(0, 9'h000, 9'h010, 0, 0, 0, 0,  4, 9'h000, 0, 0, 0, 0, 0, 0, 1);
      add(0, 9'h010, 9'h010, 0, 0, 0, 0,  1, 9'h000, 0, 1, 1, 0, 0, 0, 1); // occupied press
      add(0, 9'h054, 9'h010, 0, 0, 0, 0,  1, 9'h000, 0, 1, 0, 0, 0, 0, 1); // btn2+btn6, btn4 held
      add(0, 9'h000, 9'h010, 0, 0, 0, 0,  3, 9'h004, 1, 1, 0, 0, 0, 0, 1); // lowest wins
      add(0, 9'h000, 9'h014, 0, 0, 0, 0,  4, 9'h000, 0, 1, 0, 0, 0, 0, 2);
      add(0, 9'h001, 9'h014, 1, 0, 0, 0,  1, 9'h000, 0, 0, 0, 0, 0, 0, 2); // AI mode on
      add(0, 9'h001, 9'h014, 1, 0, 0, 0,  3, 9'h001, 0, 0, 0, 0, 0, 0, 2);
      add(0, 9'h000, 9'h015, 1, 0, 0, 0,  4, 9'h000, 0, 0, 0, 0, 0, 0, 3);
      add(0, 9'h002, 9'h015, 1, 0, 0, 0,  2, 9'h000, 0, 1, 0, 0, 1, 0, 3); // ai_start, btn ignored
      add(0, 9'h002, 9'h015, 1, 1, 12, 0, 2, 9'h000, 0, 1, 1, 0, 0, 0, 3); // comp_cell 12
      add(0, 9'h000, 9'h015, 1, 0, 0, 0,  3, 9'h002, 1, 1, 0, 0, 0, 0, 3); // lowest free = b
      add(0, 9'h000, 9'h017, 1, 0, 0, 0,  4, 9'h000, 0, 1, 0, 0, 0, 0, 4);
      add(0, 9'h000, 9'h017, 1, 1, 3, 0,  1, 9'h000, 0, 0, 0, 0, 0, 0, 4); // comp_valid ignored
      add(0, 9'h008, 9'h017, 1, 0, 0, 0,  1, 9'h000, 0, 0, 0, 0, 0, 0, 4);
      add(0, 9'h000, 9'h017, 1, 0, 0, 0,  3, 9'h008, 0, 0, 0, 0, 0, 0, 4);
      add(0, 9'h000, 9'h01F, 1, 0, 0, 0,  4, 9'h000, 0, 0, 0, 0, 0, 0, 5);
      add(0, 9'h000, 9'h01F, 1, 1, 7, 0,  2, 9'h000, 0, 1, 0, 0, 1, 0, 5); // legal AI move h
      add(0, 9'h000, 9'h01F, 1, 0, 0, 0,  3, 9'h080, 1, 1, 0, 0, 0, 0, 5);
      add(0, 9'h000, 9'h09F, 1, 0, 0, 1,  4, 9'h000, 0, 1, 0, 0, 0, 0, 6); // p1_win in CHECK
      add(0, 9'h000, 9'h09F, 1, 0, 0, 0,  5, 9'h000, 0, 1, 0, 0, 0, 1, 6);
      add(0, 9'h040, 9'h09F, 1, 0, 0, 0,  5, 9'h000, 0, 1, 0, 0, 0, 1, 6); // press in OVER
      add(1, 9'h040, 9'h09F, 1, 0, 0, 0,  5, 9'h000, 0, 1, 0, 0, 0, 1, 6); // new_game
      add(0, 9'h000, 9'h000, 0, 0, 0, 0,  0, 9'h000, 0, 0, 0, 0, 0, 0, 0);
      add(1, 9'h100, 9'h000, 0, 0, 0, 0,  1, 9'h000, 0, 0, 0, 0, 0, 0, 0); // new_game beats press
      add(0, 9'h100, 9'h000, 0, 0, 0, 0,  0, 9'h000, 0, 0, 0, 0, 0, 0, 0);
      add(0, 9'h000, 9'h000, 0, 0, 0, 0,  1, 9'h000, 0, 0, 0, 0, 0, 0, 0);

      // Reset state
      tick();
      tick();
      check("reset_outputs", 32'(outs()), 32'd0);
      reset = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         new_game = vq[i].ng; btn = vq[i].btn; occupied = vq[i].occ;
         comp_mode = vq[i].cm; comp_valid = vq[i].cv; comp_cell = vq[i].cc; p1_win = vq[i].w1;
         #1;
         check($sformatf("vec%0d", i), 32'(outs()), 32'(vq[i].exp));
         tick();
      end

      // Timeout: no legal press for T cycles; an illegal press midway does not restart the count.
      comp_mode = 1'b0; comp_valid = 1'b0; p1_win = 1'b0;
      occupied = 9'h001; btn = '0;
      new_game = 1'b1; tick();
      new_game = 1'b0; tick();
      seen = -1;
      for (int n = 0; n < T + 10 && seen < 0; n++) begin
         if (n == 5) btn = 9'h001;
         #1;
         if (n == 5) check("illegal_during_wait", 32'(illegal), 32'd1);
         if (timeout) seen = n;
         else tick();
      end
      check("timeout_cycle", 32'(seen), 32'(T - 1));
      check("timeout_state", 32'(state), 32'd1);
      tick();
      check("timeout_place", 32'({state, place, place_p2}), 32'({3'd3, 9'h002, 1'b0}));
      tick();
      check("timeout_count", 32'({state, move_count}), 32'({3'd4, 4'd1}));

      // Reset landing in the middle of COMMIT aborts the strobe.
      new_game = 1'b1; tick();
      new_game = 1'b0; tick();
      btn = 9'h081;
      #1;
      tick();
      check("pre_reset_commit", 32'(place), 32'h080);
      #2;
      reset = 1'b0;
      #1;
      check("reset_mid_commit", 32'(outs()), 32'd0);
      tick();
      check("reset_held", 32'(outs()), 32'd0);
      btn = '0;
      reset = 1'b1;
      #1;
      check("release_idle", 32'({state, place}), 32'd0);
      tick();
      check("release_wait_human", 32'({state, place, move_count}), 32'({3'd1, 9'h000, 4'd0}));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
